// File: rtl/cla_32bit.sv
// 32-bit two-level carry-lookahead adder with registered sum/cout/out_valid.
// Define CLA_32BIT_INREG_EN to add an input register stage (2-cycle latency).
module cla_32bit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   input  logic        in_valid,
   output logic [31:0] sum,
   output logic        cout,
   output logic        out_valid
);

   logic [31:0] opa;
   logic [31:0] opb;
   logic        opc;
   logic        opv;

   logic [31:0] g;
   logic [31:0] p;
   logic [31:0] c;
   logic [7:0]  grpg;
   logic [7:0]  grpp;
   logic [7:0]  grpcin;
   logic [1:0]  secg;
   logic [1:0]  secp;
   logic [1:0]  seccin;
   logic        carryout;

   // Carries into positions 0..3 of a 4-wide lookahead block, all flattened from ci.
   function automatic logic [3:0] lookahead(input logic [3:0] gi, input logic [3:0] pi,
                                            input logic ci);
      logic [3:0] cc;
      cc[0] = ci;
      cc[1] = gi[0] | (pi[0] & ci);
      cc[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
      cc[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & ci);
      return cc;
   endfunction

   function automatic logic blockgen(input logic [3:0] gi, input logic [3:0] pi);
      return gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
   endfunction

`ifdef CLA_32BIT_INREG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa <= '0;
         opb <= '0;
         opc <= 1'b0;
         opv <= 1'b0;
      end else begin
         opa <= a;
         opb <= b;
         opc <= cin;
         opv <= in_valid;
      end
   end
`else
   assign opa = a;
   assign opb = b;
   assign opc = cin;
   assign opv = in_valid;
`endif

   assign g = opa & opb;
   assign p = opa ^ opb;

   always_comb begin
      grpg = '0;
      grpp = '0;
      for (int k = 0; k < 8; k++) begin
         grpg[k] = blockgen(g[4*k +: 4], p[4*k +: 4]);
         grpp[k] = &p[4*k +: 4];
      end
   end

   always_comb begin
      secg = '0;
      secp = '0;
      for (int s = 0; s < 2; s++) begin
         secg[s] = blockgen(grpg[4*s +: 4], grpp[4*s +: 4]);
         secp[s] = &grpp[4*s +: 4];
      end
   end

   always_comb begin
      seccin[0] = opc;
      seccin[1] = secg[0] | (secp[0] & opc);
      carryout  = secg[1] | (secp[1] & secg[0]) | (secp[1] & secp[0] & opc);
   end

   always_comb begin
      grpcin = '0;
      for (int s = 0; s < 2; s++) begin
         grpcin[4*s +: 4] = lookahead(grpg[4*s +: 4], grpp[4*s +: 4], seccin[s]);
      end
   end

   // Ripple never spans more than one group: each group's bit carries come from its own cin.
   always_comb begin
      c = '0;
      for (int k = 0; k < 8; k++) begin
         c[4*k +: 4] = lookahead(g[4*k +: 4], p[4*k +: 4], grpcin[k]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= opv;
         if (opv) begin
            sum  <= p ^ c;
            cout <= carryout;
         end
      end
   end

endmodule

// File: tb/tb_cla_32bit.sv
// Self-checking bench for cla_32bit: directed table, hold, wrap and random vectors
// against a 33-bit reference add, with latency following CLA_32BIT_INREG_EN.
module tb_cla_32bit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        cin = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] sum;
   logic        cout;
   logic        out_valid;

`ifdef CLA_32BIT_INREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   int checks = 0;
   int passed = 0;

   logic [31:0] prevA = '0;
   logic [31:0] prevB = '0;
   logic        prevC = 1'b0;
   logic        prevV = 1'b0;
   logic [31:0] expSum = '0;
   logic        expCout = 1'b0;
   logic        expValid = 1'b0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] expSum;
      logic        expCout;
   } vec_t;

   localparam int NVEC = 12;
   vec_t tbl[NVEC];

   cla_32bit dut (
      .clk(clk),
      .rst_n(rst_n),
      .a(a),
      .b(b),
      .cin(cin),
      .in_valid(in_valid),
      .sum(sum),
      .cout(cout),
      .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Drives one input cycle, advances the reference model and compares all outputs.
   task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                                input logic tv);
      logic [31:0] ua;
      logic [31:0] ub;
      logic        uc;
      logic        uv;
      logic [32:0] refSum;
      @(negedge clk);
      a = ta;
      b = tb;
      cin = tc;
      in_valid = tv;
      @(posedge clk);
      #1;
`ifdef CLA_32BIT_INREG_EN
      ua = prevA;
      ub = prevB;
      uc = prevC;
      uv = prevV;
`else
      ua = ta;
      ub = tb;
      uc = tc;
      uv = tv;
`endif
      prevA = ta;
      prevB = tb;
      prevC = tc;
      prevV = tv;
      if (uv) begin
         refSum = {1'b0, ua} + {1'b0, ub} + {32'd0, uc};
         expSum = refSum[31:0];
         expCout = refSum[32];
      end
      expValid = uv;
      checkOutput("sum", {1'b0, sum}, {1'b0, expSum});
      checkOutput("cout", {32'd0, cout}, {32'd0, expCout});
      checkOutput("out_valid", {32'd0, out_valid}, {32'd0, expValid});
   endtask

   task automatic doReset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_sum", {1'b0, sum}, 33'd0);
      checkOutput("rst_cout", {32'd0, cout}, 33'd0);
      checkOutput("rst_valid", {32'd0, out_valid}, 33'd0);
      expSum = '0;
      expCout = 1'b0;
      expValid = 1'b0;
      prevA = '0;
      prevB = '0;
      prevC = 1'b0;
      prevV = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      tbl[0]  = '{32'd25,        32'd45,        1'b0, 32'd70,        1'b0};
      tbl[1]  = '{32'd300,       32'd45,        1'b0, 32'd345,       1'b0};
      tbl[2]  = '{32'd300,       32'd650,       1'b1, 32'd951,       1'b0};
      tbl[3]  = '{32'd1423,      32'd650,       1'b1, 32'd2074,      1'b0};
      tbl[4]  = '{32'd1423,      32'd4986,      1'b0, 32'd6409,      1'b0};
      tbl[5]  = '{32'hFFFFFFFF,  32'h00000000,  1'b1, 32'h00000000,  1'b1};
      tbl[6]  = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 32'hFFFFFFFF,  1'b1};
      tbl[7]  = '{32'h80000000,  32'h80000000,  1'b0, 32'h00000000,  1'b1};
      tbl[8]  = '{32'h12345678,  32'h9ABCDEF0,  1'b0, 32'hACF13568,  1'b0};
      tbl[9]  = '{32'h7FFFFFFF,  32'h00000001,  1'b0, 32'h80000000,  1'b0};
      tbl[10] = '{32'hFFFF0000,  32'h0000FFFF,  1'b1, 32'h00000000,  1'b1};
      tbl[11] = '{32'h0000FFFF,  32'h00000001,  1'b0, 32'h00010000,  1'b0};

      repeat (2) @(posedge clk);
      doReset();

      // Back-to-back table vectors; result for vector i appears LAT-1 steps later.
      for (int i = 0; i < NVEC + LAT - 1; i++) begin
         if (i < NVEC) applyStimulus(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b1);
         else applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);
         if (i >= LAT - 1) begin
            checkOutput("tbl_sum", {1'b0, sum}, {1'b0, tbl[i - LAT + 1].expSum});
            checkOutput("tbl_cout", {32'd0, cout}, {32'd0, tbl[i - LAT + 1].expCout});
         end
      end

      // Hold: idle cycles with changing operands must not disturb the last result.
      applyStimulus(32'd100, 32'd200, 1'b0, 1'b1);
      applyStimulus(32'd7, 32'd9, 1'b1, 1'b0);
      applyStimulus(32'd55, 32'd66, 1'b0, 1'b0);
      checkOutput("hold_sum", {1'b0, sum}, 33'd300);
      checkOutput("hold_cout", {32'd0, cout}, 33'd0);
      checkOutput("hold_valid", {32'd0, out_valid}, 33'd0);

      // Reset mid-stream, then first accepted result must appear after LAT.
      applyStimulus(32'hDEADBEEF, 32'h01234567, 1'b1, 1'b1);
      doReset();
      applyStimulus(32'd1, 32'd2, 1'b0, 1'b1);
      if (LAT == 2) checkOutput("post_rst_valid0", {32'd0, out_valid}, 33'd0);
      applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);

      for (int i = 0; i < 10000; i++) begin
         if (i % 2500 == 1250) doReset();
         applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 7) != 0));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/cla_32bit.md
# cla_32bit

32-bit carry-lookahead adder with registered result, used as the fast-add datapath element wherever a 32-bit sum plus carry-out is needed in one clock. Carries are computed by a two-level lookahead tree (4-bit groups, then 4-group sections), not by ripple. Inputs are sampled on the rising clock edge and the result is presented from output registers.

## Interface
- No parameters; width fixed at 32.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- a  input  32  unsigned operand A
- b  input  32  unsigned operand B
- cin  input  1  carry-in
- in_valid  input  1  qualifies a/b/cin this cycle
- sum  output  32  registered (a + b + cin) mod 2^32
- cout  output  1  registered carry-out, bit 32 of a + b + cin
- out_valid  output  1  sum/cout hold a result for an accepted input

## Operation
- Bit level: g[i] = a[i] & b[i], p[i] = a[i] ^ b[i]; sum[i] = p[i] ^ c[i], c[0] = cin.
- Level 1: eight 4-bit CLA groups.
  - Each group produces internal carries directly from g/p and the group carry-in.
  - Each group also produces group generate G and group propagate P.
- Level 2: two 16-bit sections, each doing lookahead over 4 groups.
  - Produces section G/P and the group carry-ins.
- Top: section 1 carry-in = G0 | P0&cin; cout = G1 | P1&G0 | P1&P0&cin.
- No ripple path longer than one 4-bit group is permitted.
- Arithmetic is unsigned, with no overflow flag.
  - Wrap-around: 0xFFFFFFFF + 0 + 1 gives sum 0 and cout 1.
- in_valid = 0: sum/cout registers hold their previous value; out_valid deasserts next cycle.
- Adder logic is purely combinational between the input sample point and the output registers.

## Timing
- Reset (rst_n low, asynchronous) clears sum, cout and out_valid to 0 immediately, independent of clk.
- Reset deasserts synchronously to the design: the first capture is on the first rising clk edge with rst_n high.
- Latency is 1 cycle in the default build: inputs present with in_valid at edge N give sum/cout/out_valid at edge N.
- Throughput is one add per cycle, with no stall or backpressure.
- Back-to-back inputs each produce a result on consecutive cycles.
- Reset mid-stream discards all in-flight results; out_valid stays 0 until a new accepted input.

## Configuration
- CLA_32BIT_INREG_EN defined:
  - Adds an input register stage on a, b, cin and in_valid, also cleared by rst_n.
  - Latency becomes 2 cycles; the adder path runs register to register.
- Not defined: single output register stage, 1-cycle latency as above.
- Function and reset behaviour are otherwise identical in both builds.

## Test plan
- Reset: assert rst_n = 0 between clock edges -> sum = 0, cout = 0, out_valid = 0 immediately.
- Sequence with in_valid = 1, one vector per cycle -> sum values in order:
  - a = 25, b = 45, cin = 0 -> 70
  - a = 300, b = 45, cin = 0 -> 345
  - a = 300, b = 650, cin = 1 -> 951
  - a = 1423, b = 650, cin = 1 -> 2074
  - a = 1423, b = 4986, cin = 0 -> 6409
  - All with cout = 0, each at the configured latency.
- Carry chain wrap: a = 0xFFFFFFFF, b = 0, cin = 1 -> sum = 0x00000000, cout = 1.
- Max: a = 0xFFFFFFFF, b = 0xFFFFFFFF, cin = 1 -> sum = 0xFFFFFFFF, cout = 1.
- Hold: in_valid = 0 with changing a/b -> sum/cout unchanged, out_valid = 0 on the next cycle.
- Random: 10k random a/b/cin vectors vs. a 33-bit reference add, checked in both CLA_32BIT_INREG_EN builds, including reset asserted mid-stream.
